// File: rtl/datamemory_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// Optional macro ADDR_RANGE_CHECK_EN blocks writes/reads at addr >= DEPTH and raises err_x.
module datamemory_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_a,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    output logic                  ack_a,
    output logic [DATA_WIDTH-1:0] rdata_a,
    output logic                  err_a,
    input  logic                  req_b,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    output logic                  ack_b,
    output logic [DATA_WIDTH-1:0] rdata_b,
    output logic                  err_b,
    output logic                  mem_regWE,
    output logic [ADDR_WIDTH-1:0] mem_Addr,
    output logic [DATA_WIDTH-1:0] mem_DataIn,
    input  logic [DATA_WIDTH-1:0] mem_DataOut
);

    // state  | meaning
    // IDLE   | no access in flight, arbitrate at next edge
    // BUSY_A | port A access driving the memory this cycle
    // BUSY_B | port B access driving the memory this cycle
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_A = 2'd1,
        BUSY_B = 2'd2
    } state_t;

    state_t                  state_q;
    logic                    last_b_q;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    ack_a_q;
    logic                    ack_b_q;
    logic [DATA_WIDTH-1:0]   rdata_a_q;
    logic [DATA_WIDTH-1:0]   rdata_b_q;

    logic elig_a;
    logic elig_b;
    logic grant_a_d;
    logic grant_b_d;
    logic busy;
    logic addr_ok;

    // A request seen during its own ack cycle is the tail of the finished access.
    assign elig_a    = req_a && !ack_a_q;
    assign elig_b    = req_b && !ack_b_q;
    assign grant_a_d = elig_a && (!elig_b || last_b_q);
    assign grant_b_d = elig_b && !grant_a_d;

    assign busy = (state_q != IDLE);

`ifdef ADDR_RANGE_CHECK_EN
    logic err_a_q;
    logic err_b_q;
    assign addr_ok = (addr_q < ADDR_WIDTH'(DEPTH));
    assign err_a   = err_a_q;
    assign err_b   = err_b_q;
`else
    assign addr_ok = 1'b1;
    assign err_a   = 1'b0;
    assign err_b   = 1'b0;
`endif

    // Decoded from state so an async reset removes the write strobe at once.
    assign mem_regWE  = busy && we_q && addr_ok;
    assign mem_Addr   = busy ? addr_q  : '0;
    assign mem_DataIn = busy ? wdata_q : '0;

    assign ack_a   = ack_a_q;
    assign ack_b   = ack_b_q;
    assign rdata_a = rdata_a_q;
    assign rdata_b = rdata_b_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            last_b_q  <= 1'b1;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ack_a_q   <= 1'b0;
            ack_b_q   <= 1'b0;
            rdata_a_q <= '0;
            rdata_b_q <= '0;
`ifdef ADDR_RANGE_CHECK_EN
            err_a_q   <= 1'b0;
            err_b_q   <= 1'b0;
`endif
        end else begin
            ack_a_q <= 1'b0;
            ack_b_q <= 1'b0;
`ifdef ADDR_RANGE_CHECK_EN
            err_a_q <= 1'b0;
            err_b_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (grant_a_d) begin
                        state_q  <= BUSY_A;
                        last_b_q <= 1'b0;
                        we_q     <= we_a;
                        addr_q   <= addr_a;
                        wdata_q  <= wdata_a;
                    end else if (grant_b_d) begin
                        state_q  <= BUSY_B;
                        last_b_q <= 1'b1;
                        we_q     <= we_b;
                        addr_q   <= addr_b;
                        wdata_q  <= wdata_b;
                    end
                end
                BUSY_A: begin
                    ack_a_q <= 1'b1;
                    if (!we_q && addr_ok) rdata_a_q <= mem_DataOut;
`ifdef ADDR_RANGE_CHECK_EN
                    err_a_q <= !addr_ok;
`endif
                    state_q <= IDLE;
                end
                BUSY_B: begin
                    ack_b_q <= 1'b1;
                    if (!we_q && addr_ok) rdata_b_q <= mem_DataOut;
`ifdef ADDR_RANGE_CHECK_EN
                    err_b_q <= !addr_ok;
`endif
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
